selection_sort_axil_slave: RTL and testbench
============================================

# selection_sort_axil_slave

AXI4-Lite slave register file and sequential sort engine for the selection-sort IP. It responds to the AXI4-Lite master, which is the VIP master agent in simulation and the PS in hardware. It holds four 32-bit input words and sorts them with a selection-sort FSM when software issues START. The sorted result is exposed as read-only registers.

## Interface
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6, byte address width; covers 0x00–0x3F.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- s_axi_awaddr / awprot / awvalid / awready  in/in/in/out  6/3/1/1  write address channel; awprot is ignored.
- s_axi_wdata / wstrb / wvalid / wready  in/in/in/out  32/4/1/1  write data channel.
- s_axi_bresp / bvalid / bready  out/out/in  2/1/1  write response channel.
- s_axi_araddr / arprot / arvalid / arready  in/in/in/out  6/3/1/1  read address channel; arprot is ignored.
- s_axi_rdata / rresp / rvalid / rready  out/out/out/in  32/2/1/1  read data channel.
- done_irq  out  1  one-cycle pulse when a sort completes.

## Operation
Register map (word addresses; awaddr[1:0] and araddr[1:0] are ignored):
- 0x00–0x0C DATA0..3: read/write, with byte strobes.
- 0x10 CTRL:
  - bit0 START: write-1 pulse; always reads 0.
  - bit1 DESC: read/write; 0 = ascending, 1 = descending.
- 0x14 STATUS: read-only. bit0 BUSY; bit1 DONE (sticky, cleared by an accepted START).
- 0x18–0x24 SORTED0..3: read-only.
- Unmapped addresses read 0. Writes to read-only or unmapped addresses are ignored. Every response is OKAY (2'b00); SLVERR is never generated.

Sort FSM states:
- IDLE: on an accepted START, snapshot DATA0..3 and DESC into work[0..3] and go to LOAD. START while BUSY is ignored.
- LOAD: set i=0, sel=0, j=1; go to SCAN.
- SCAN: compare work[j] with work[sel] as unsigned values.
  - Ascending: sel←j if work[j] < work[sel]. Descending: sel←j if work[j] > work[sel].
  - Comparison is strict, so ties keep the lower index.
  - j increments each cycle; after the j=3 compare, go to SWAP.
- SWAP: exchange work[i] and work[sel].
  - If i==2, go to FIN.
  - Otherwise i←i+1, sel←i+1, j←i+2, and go to SCAN.
- FIN: copy work into SORTED0..3, set DONE, pulse done_irq, go to IDLE.

Writes to DATA during BUSY are accepted and do not affect the running sort.

## Timing
- Reset: every output is 0 (awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata, done_irq). All registers are 0 and the FSM is in IDLE.
- A reset mid-sort aborts the sort: BUSY=0, DONE=0, SORTED=0. Any pending bvalid or rvalid is dropped.
- Write path:
  - awready and wready pulse together for one cycle when awvalid && wvalid && !bvalid && !(awready).
  - The register update happens on that edge.
  - bvalid rises the next cycle and holds until bready; no new write is accepted while bvalid=1.
- Read path:
  - arready pulses for one cycle when arvalid && !rvalid && !arready.
  - rdata is captured on the same edge and rvalid rises the next cycle, holding with stable rdata until rready.
  - If a read and a write to the same register handshake on the same edge, the read returns the pre-write value.
- Sort timing:
  - The START write handshake edge is cycle 0; BUSY=1 from cycle 1.
  - LOAD takes 1 cycle; the scan/swap sequence is 3+1, 2+1, 1+1; FIN takes 1 cycle.
  - BUSY is high for exactly 11 cycles.
  - SORTED, DONE and done_irq update on the FIN edge; BUSY reads 0 from the next cycle.

## Test plan
- Write 1,2,3,4 to 0x00,0x04,0x08,0x0C, then read the same addresses -> 1,2,3,4 returned; every BRESP and RRESP is OKAY.
- DATA = 7,3,9,1; write CTRL=0x1 -> BUSY for exactly 11 cycles, one done_irq pulse, STATUS=0x2, SORTED = 1,3,7,9.
- DATA = 5,5,0xFFFFFFFF,0; write CTRL=0x3 -> SORTED = 0xFFFFFFFF,5,5,0 (unsigned compare); CTRL reads 0x2.
- DATA0 = 0x11223344; write 0xAABBCCDD with WSTRB=4'b0010 -> DATA0 reads 0x1122CC44. A write to 0x18 and a read of 0x30 -> SORTED0 is unchanged and the read returns 0.
- Hold bready low for 5 cycles after a write -> bvalid stays high, and a second AW/W presented meanwhile gets no awready until one cycle after the B handshake.
- Assert reset for one cycle in cycle 5 of a sort -> STATUS=0, SORTED=0, no done_irq; a subsequent START sorts normally.

Source files
------------

// File: rtl/selection_sort_axil_slave.sv
// AXI4-Lite register file with a four-word selection-sort engine.
// DATA/CTRL are software-writable; SORTED and STATUS are read-only results.
module selection_sort_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic                            done_irq
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = DW / 8;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_SWAP, S_FIN} state_t;

    state_t        state_q;
    logic [DW-1:0] data_q   [4];
    logic [DW-1:0] sorted_q [4];
    logic [DW-1:0] work_q   [4];
    logic          desc_q, work_desc_q, done_q;
    logic [1:0]    i_q, sel_q, j_q;

    logic          awready_q, wready_q, bvalid_q, arready_q, rvalid_q, done_irq_q;
    logic [DW-1:0] rdata_q, rdata_d;

    logic [3:0]    wr_idx, rd_idx, sorted_idx;
    logic          wr_hs, rd_hs, busy, start_acc, take_j;
    logic          unused_bits;

    assign wr_idx      = s_axi_awaddr[5:2];
    assign rd_idx      = s_axi_araddr[5:2];
    assign sorted_idx  = rd_idx - 4'd6;
    assign wr_hs       = awready_q && wready_q && s_axi_awvalid && s_axi_wvalid;
    assign rd_hs       = arready_q && s_axi_arvalid;
    assign busy        = (state_q != S_IDLE);
    assign start_acc   = wr_hs && (wr_idx == 4'd4) && s_axi_wstrb[0] && s_axi_wdata[0] && !busy;
    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Strict compare: equal keys never move, so ties keep the lower index.
    assign take_j = work_desc_q ? (work_q[j_q] > work_q[sel_q])
                                : (work_q[j_q] < work_q[sel_q]);

    always_comb begin
        rdata_d = '0;
        case (rd_idx)
            4'd0, 4'd1, 4'd2, 4'd3: rdata_d = data_q[rd_idx[1:0]];
            4'd4:                   rdata_d[1] = desc_q;
            4'd5:                   rdata_d[1:0] = {done_q, busy};
            4'd6, 4'd7, 4'd8, 4'd9: rdata_d = sorted_q[sorted_idx[1:0]];
            default:                rdata_d = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            desc_q      <= 1'b0;
            work_desc_q <= 1'b0;
            done_q      <= 1'b0;
            i_q         <= 2'd0;
            sel_q       <= 2'd0;
            j_q         <= 2'd0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            done_irq_q  <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                data_q[k]   <= '0;
                sorted_q[k] <= '0;
                work_q[k]   <= '0;
            end
        end else begin
            done_irq_q <= 1'b0;

            // Write channel: one-cycle ready pulse, then hold B until accepted.
            awready_q <= s_axi_awvalid && s_axi_wvalid && !bvalid_q && !awready_q;
            wready_q  <= s_axi_awvalid && s_axi_wvalid && !bvalid_q && !awready_q;
            if (wr_hs) begin
                bvalid_q <= 1'b1;
                if (wr_idx < 4'd4) begin
                    for (int b = 0; b < NB; b++)
                        if (s_axi_wstrb[b])
                            data_q[wr_idx[1:0]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end else if (wr_idx == 4'd4 && s_axi_wstrb[0]) begin
                    desc_q <= s_axi_wdata[1];
                end
            end else if (bvalid_q && s_axi_bready) begin
                bvalid_q <= 1'b0;
            end

            // Read channel: rdata sampled on the AR handshake edge.
            arready_q <= s_axi_arvalid && !rvalid_q && !arready_q;
            if (rd_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
            end else if (rvalid_q && s_axi_rready) begin
                rvalid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (start_acc) begin
                        for (int k = 0; k < 4; k++) work_q[k] <= data_q[k];
                        work_desc_q <= s_axi_wdata[1];
                        done_q      <= 1'b0;
                        state_q     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    i_q     <= 2'd0;
                    sel_q   <= 2'd0;
                    j_q     <= 2'd1;
                    state_q <= S_SCAN;
                end
                S_SCAN: begin
                    if (take_j) sel_q <= j_q;
                    if (j_q == 2'd3) state_q <= S_SWAP;
                    else             j_q     <= j_q + 2'd1;
                end
                S_SWAP: begin
                    work_q[i_q]   <= work_q[sel_q];
                    work_q[sel_q] <= work_q[i_q];
                    if (i_q == 2'd2) begin
                        state_q <= S_FIN;
                    end else begin
                        i_q     <= i_q + 2'd1;
                        sel_q   <= i_q + 2'd1;
                        j_q     <= i_q + 2'd2;
                        state_q <= S_SCAN;
                    end
                end
                S_FIN: begin
                    for (int k = 0; k < 4; k++) sorted_q[k] <= work_q[k];
                    done_q     <= 1'b1;
                    done_irq_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;
    assign done_irq      = done_irq_q;

endmodule

// File: tb/tb_selection_sort_axil_slave.sv
// Directed bench for selection_sort_axil_slave: register access, sort results,
// sort latency, byte strobes, B back-pressure and reset mid-sort.
module tb_selection_sort_axil_slave;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  s_axi_awaddr = '0;
    logic [2:0]  s_axi_awprot = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [5:0]  s_axi_araddr = '0;
    logic [2:0]  s_axi_arprot = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic        done_irq;

    int npass = 0;
    int ntotal = 0;
    int cyc = 0;
    int irq_cnt = 0;
    int irq_cyc = 0;

    selection_sort_axil_slave dut (
        .clock(clock), .reset(reset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .done_irq(done_irq)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) if (done_irq) begin
        irq_cnt <= irq_cnt + 1;
        irq_cyc <= cyc;
    end

    // hs returns the cycle number of the AW/W handshake edge.
    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output int hs);
        bit ok = 0;
        resp = 2'b11; hs = -1;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_bready = 1;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clock);
            if (s_axi_awready && s_axi_wready) ok = 1;
        end
        if (!ok) begin
            ntotal++;
            $display("FAIL wr_timeout addr=%h: no awready/wready within 20 cycles", a);
            s_axi_awvalid = 0; s_axi_wvalid = 0;
            return;
        end
        @(posedge clock); #1;
        hs = cyc;
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clock);
            if (s_axi_bvalid) begin ok = 1; resp = s_axi_bresp; end
        end
        if (!ok) begin
            ntotal++;
            $display("FAIL b_timeout addr=%h: no bvalid within 20 cycles", a);
        end
        @(posedge clock); #1;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit ok = 0;
        d = 'x; resp = 2'b11;
        s_axi_araddr = a; s_axi_arvalid = 1; s_axi_rready = 1;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clock);
            if (s_axi_arready) ok = 1;
        end
        if (!ok) begin
            ntotal++;
            $display("FAIL rd_timeout addr=%h: no arready within 20 cycles", a);
            s_axi_arvalid = 0;
            return;
        end
        @(posedge clock); #1;
        s_axi_arvalid = 0;
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clock);
            if (s_axi_rvalid) begin ok = 1; d = s_axi_rdata; resp = s_axi_rresp; end
        end
        if (!ok) begin
            ntotal++;
            $display("FAIL r_timeout addr=%h: no rvalid within 20 cycles", a);
        end
        @(posedge clock); #1;
    endtask

    task automatic wait_irq(input int start_cnt);
        for (int n = 0; n < 40 && irq_cnt == start_cnt; n++) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r;
        @(negedge clock);
        ntotal++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
             s_axi_rvalid, s_axi_rresp, s_axi_rdata, done_irq} !== '0)
            $display("FAIL reset_outputs: got nonzero outputs (rdata=%h) required all 0", s_axi_rdata);
        else npass++;
        @(posedge clock); #1 reset = 0;
        axi_read(6'h14, d, r);
        ntotal++;
        if (d !== 32'h0) $display("FAIL reset_status: got %h required 0", d); else npass++;
        axi_read(6'h18, d, r);
        ntotal++;
        if (d !== 32'h0) $display("FAIL reset_sorted0: got %h required 0", d); else npass++;
    endtask

    task automatic test_data_rw();
        logic [31:0] d; logic [1:0] r; int hs;
        logic [1:0] resp_or = 2'b00;
        for (int k = 0; k < 4; k++) begin
            axi_write(6'(4*k), 32'(k+1), 4'hF, r, hs);
            resp_or |= r;
        end
        for (int k = 0; k < 4; k++) begin
            axi_read(6'(4*k), d, r);
            resp_or |= r;
            ntotal++;
            if (d !== 32'(k+1)) $display("FAIL data_rw[%0d]: got %h required %h", k, d, k+1);
            else npass++;
        end
        ntotal++;
        if (resp_or !== 2'b00) $display("FAIL resp_okay: got %b required 00", resp_or); else npass++;
    endtask

    task automatic load_data(input logic [31:0] a0, a1, a2, a3);
        logic [1:0] r; int hs;
        axi_write(6'h00, a0, 4'hF, r, hs);
        axi_write(6'h04, a1, 4'hF, r, hs);
        axi_write(6'h08, a2, 4'hF, r, hs);
        axi_write(6'h0C, a3, 4'hF, r, hs);
    endtask

    task automatic check_sorted(input string nm, input logic [31:0] e0, e1, e2, e3);
        logic [31:0] d; logic [1:0] r;
        logic [31:0] exp [4];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        for (int k = 0; k < 4; k++) begin
            axi_read(6'(8'h18 + 4*k), d, r);
            ntotal++;
            if (d !== exp[k]) $display("FAIL %s_sorted%0d: got %h required %h", nm, k, d, exp[k]);
            else npass++;
        end
    endtask

    task automatic test_sort_asc();
        logic [31:0] d; logic [1:0] r; int hs; int c0;
        load_data(32'd7, 32'd3, 32'd9, 32'd1);
        c0 = irq_cnt;
        axi_write(6'h10, 32'h1, 4'hF, r, hs);
        axi_read(6'h14, d, r);
        ntotal++;
        if (d !== 32'h1) $display("FAIL asc_busy: status got %h required 1", d); else npass++;
        wait_irq(c0);
        repeat (3) @(posedge clock); #1;
        ntotal++;
        if (irq_cnt - c0 !== 1) $display("FAIL asc_irq_count: got %0d required 1", irq_cnt - c0);
        else npass++;
        ntotal++;
        if (irq_cyc - hs !== 11) $display("FAIL asc_latency: irq %0d cycles after start, required 11", irq_cyc - hs);
        else npass++;
        axi_read(6'h14, d, r);
        ntotal++;
        if (d !== 32'h2) $display("FAIL asc_status: got %h required 2", d); else npass++;
        check_sorted("asc", 32'd1, 32'd3, 32'd7, 32'd9);
    endtask

    task automatic test_sort_desc();
        logic [31:0] d; logic [1:0] r; int hs; int c0;
        load_data(32'd5, 32'd5, 32'hFFFF_FFFF, 32'd0);
        c0 = irq_cnt;
        axi_write(6'h10, 32'h3, 4'hF, r, hs);
        wait_irq(c0);
        ntotal++;
        if (irq_cnt - c0 !== 1) $display("FAIL desc_irq_count: got %0d required 1", irq_cnt - c0);
        else npass++;
        check_sorted("desc", 32'hFFFF_FFFF, 32'd5, 32'd5, 32'd0);
        axi_read(6'h10, d, r);
        ntotal++;
        if (d !== 32'h2) $display("FAIL desc_ctrl_read: got %h required 2", d); else npass++;
    endtask

    task automatic test_strobe_unmapped();
        logic [31:0] d; logic [1:0] r; int hs;
        axi_write(6'h00, 32'h1122_3344, 4'hF, r, hs);
        axi_write(6'h00, 32'hAABB_CCDD, 4'b0010, r, hs);
        axi_read(6'h00, d, r);
        ntotal++;
        if (d !== 32'h1122_CC44) $display("FAIL wstrb: got %h required 1122cc44", d); else npass++;
        axi_write(6'h18, 32'h1234_5678, 4'hF, r, hs);
        axi_read(6'h18, d, r);
        ntotal++;
        if (d !== 32'hFFFF_FFFF) $display("FAIL ro_sorted0: got %h required ffffffff", d); else npass++;
        axi_write(6'h30, 32'h5555_5555, 4'hF, r, hs);
        axi_read(6'h30, d, r);
        ntotal++;
        if (d !== 32'h0) $display("FAIL unmapped_read: got %h required 0", d); else npass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic [1:0] r;
        bit ok = 0; bit bad = 0;
        s_axi_awaddr = 6'h0C; s_axi_wdata = 32'h0000_CAFE; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_bready = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clock);
            if (s_axi_awready) ok = 1;
        end
        @(posedge clock); #1;
        s_axi_awaddr = 6'h08; s_axi_wdata = 32'h0000_BEEF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (!s_axi_bvalid || s_axi_awready) bad = 1;
        end
        ntotal++;
        if (!ok || bad) $display("FAIL bp_hold: ok=%0d bad=%0d required ok=1 bad=0", ok, bad);
        else npass++;
        s_axi_bready = 1;
        @(posedge clock); #1;
        @(negedge clock);
        ntotal++;
        if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b0)
            $display("FAIL bp_after_b: bvalid=%b awready=%b required 0 0", s_axi_bvalid, s_axi_awready);
        else npass++;
        @(posedge clock); #1;
        @(negedge clock);
        ntotal++;
        if (s_axi_awready !== 1'b1) $display("FAIL bp_second_aw: awready=%b required 1", s_axi_awready);
        else npass++;
        @(posedge clock); #1;
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        @(negedge clock);
        ntotal++;
        if (s_axi_bvalid !== 1'b1) $display("FAIL bp_second_b: bvalid=%b required 1", s_axi_bvalid);
        else npass++;
        @(posedge clock); #1;
        axi_read(6'h0C, d, r);
        ntotal++;
        if (d !== 32'h0000_CAFE) $display("FAIL bp_data3: got %h required 0000cafe", d); else npass++;
        axi_read(6'h08, d, r);
        ntotal++;
        if (d !== 32'h0000_BEEF) $display("FAIL bp_data2: got %h required 0000beef", d); else npass++;
    endtask

    task automatic test_reset_mid_sort();
        logic [31:0] d; logic [1:0] r; int hs; int c0;
        load_data(32'd40, 32'd10, 32'd30, 32'd20);
        c0 = irq_cnt;
        axi_write(6'h10, 32'h1, 4'hF, r, hs);
        for (int n = 0; n < 20 && cyc < hs + 4; n++) @(posedge clock);
        #1 reset = 1;
        @(posedge clock); #1 reset = 0;
        repeat (20) @(posedge clock); #1;
        ntotal++;
        if (irq_cnt !== c0) $display("FAIL rst_no_irq: got %0d pulses required 0", irq_cnt - c0);
        else npass++;
        axi_read(6'h14, d, r);
        ntotal++;
        if (d !== 32'h0) $display("FAIL rst_status: got %h required 0", d); else npass++;
        check_sorted("rst", 32'd0, 32'd0, 32'd0, 32'd0);
        load_data(32'd4, 32'd2, 32'd8, 32'd6);
        c0 = irq_cnt;
        axi_write(6'h10, 32'h1, 4'hF, r, hs);
        wait_irq(c0);
        ntotal++;
        if (irq_cnt - c0 !== 1) $display("FAIL rst_resort_irq: got %0d required 1", irq_cnt - c0);
        else npass++;
        check_sorted("resort", 32'd2, 32'd4, 32'd6, 32'd8);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        test_reset();
        test_data_rw();
        test_sort_asc();
        test_sort_desc();
        test_strobe_unmapped();
        test_back_to_back();
        test_reset_mid_sort();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
